// File: rtl/alu_seq_pkg.sv
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared state encoding, opcode table and constants for the
//                ALU test sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AUTO  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam logic [3:0] SUB_OP       = 4'b0110;
  localparam int         DEBOUNCE_CYC = 1_000_000;

  // Entry i sits at bits [4*i +: 4]: AND, OR, ADD, SUB, SLTU, SLR, SLL, SRA.
  localparam logic [31:0] OP_TABLE = {
    4'b1001, 4'b1000, 4'b0111, 4'b0101,
    4'b0110, 4'b0010, 4'b0001, 4'b0000
  };

  function automatic logic [3:0] op_lookup(input logic [2:0] idx);
    return OP_TABLE[{idx, 2'b00} +: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_btn_sync.sv
// ============================================================================
//  Module      : alu_seq_btn_sync
//  Description : Push-button synchronizer, optional debouncer (macro
//                ALU_SEQ_DEBOUNCE_EN) and rising-edge detector -> step_p.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_btn_sync
  import alu_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step_p
);

  logic [1:0] sync;
  logic       level;
  logic       level_q;
  logic       step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], btn};
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [DB_W-1:0] db_cnt;
  logic            db_level;

  // Level follows the synchronized input only after it has differed for the full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync[1] == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= sync[1];
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      level_q <= level;
      step_q  <= level & ~level_q;
    end
  end

  assign step_p = step_q;

endmodule

`default_nettype wire

// File: rtl/alu_test_sequencer.sv
// ============================================================================
//  Module      : alu_test_sequencer
//  Description : Walks addrb x addra x opcode for the ALU demo, auto-dwell or
//                push-button stepping. Optional debounce: ALU_SEQ_DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_test_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DWELL  = 50_000_000,
  parameter int ADDR_W = 3,
  parameter int OP_CNT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  run_i,
  input  logic                  step_i,
  output logic [ADDR_W-1:0]     addra_o,
  output logic [ADDR_W-1:0]     addrb_o,
  output logic [3:0]            operacion_o,
  output logic                  invert_o,
  output logic                  c_o,
  output logic [2*ADDR_W+2:0]   index_o,
  output logic                  adv_o,
  output logic                  done_o
);

  localparam int                CNT_W      = $clog2(DWELL);
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
  localparam logic [2:0]        OP_LAST    = 3'(OP_CNT - 1);

  seq_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] addra, addra_n;
  logic [ADDR_W-1:0] addrb, addrb_n;
  logic [2:0]        op_idx, op_n;
  logic              adv, adv_n;
  logic              do_adv;
  logic              is_last;
  logic [1:0]        run_sync;
  logic              run_s;
  logic              step_p;

  alu_seq_btn_sync u_btn_sync (
    .clk    (clk_i),
    .rst    (rst_i),
    .btn    (step_i),
    .step_p (step_p)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_sync <= 2'b00;
    end else begin
      run_sync <= {run_sync[0], run_i};
    end
  end

  assign run_s   = run_sync[1];
  assign is_last = (addrb == ADDR_MAX) && (addra == ADDR_MAX) && (op_idx == OP_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addra_n = addra;
    addrb_n = addrb;
    op_n    = op_idx;
    adv_n   = 1'b0;
    do_adv  = 1'b0;

    case (state)
      IDLE: begin
        if (run_s) begin
          state_n = AUTO;
          cnt_n   = '0;
        end else if (step_p) begin
          state_n = PAUSE;
        end
      end
      AUTO: begin
        if (!run_s) begin
          state_n = PAUSE;
        end else if (cnt == DWELL_LAST) begin
          if (is_last) begin
            state_n = DONE;
          end else begin
            do_adv = 1'b1;
            cnt_n  = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PAUSE: begin
        // A run request wins over a coincident step; the frozen count resumes.
        if (run_s) begin
          state_n = AUTO;
        end else if (step_p) begin
          if (is_last) begin
            state_n = DONE;
          end else begin
            do_adv = 1'b1;
          end
        end
      end
      DONE: begin
        if (!run_s) begin
          state_n = IDLE;
          cnt_n   = '0;
          addra_n = '0;
          addrb_n = '0;
          op_n    = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_adv) begin
      adv_n   = 1'b1;
      addrb_n = addrb + 1'b1;
      if (addrb == ADDR_MAX) begin
        addra_n = addra + 1'b1;
        if (addra == ADDR_MAX) begin
          op_n = (op_idx == OP_LAST) ? 3'd0 : op_idx + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      addra  <= '0;
      addrb  <= '0;
      op_idx <= '0;
      adv    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addra  <= addra_n;
      addrb  <= addrb_n;
      op_idx <= op_n;
      adv    <= adv_n;
    end
  end

  assign addra_o     = addra;
  assign addrb_o     = addrb;
  assign operacion_o = op_lookup(op_idx);
  assign invert_o    = (operacion_o == SUB_OP);
  assign c_o         = (operacion_o == SUB_OP);
  assign index_o     = {op_idx, addra, addrb};
  assign adv_o       = adv;
  assign done_o      = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_alu_test_sequencer.sv
// ============================================================================
//  Module      : tb_alu_test_sequencer
//  Description : Directed self-checking bench for alu_test_sequencer (DWELL=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_test_sequencer;

  localparam int DWELL  = 4;
  localparam int ADDR_W = 3;
  localparam int OP_CNT = 8;
  localparam int IW     = 2*ADDR_W + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic              step;
  logic [ADDR_W-1:0] addra, addrb;
  logic [3:0]        operacion;
  logic              invert, c;
  logic [IW-1:0]     index;
  logic              adv, done;

  int checks = 0;
  int errors = 0;
  int cyc;
  int exp_idx;
  int adv_seen;

  alu_test_sequencer #(.DWELL(DWELL), .ADDR_W(ADDR_W), .OP_CNT(OP_CNT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .run_i       (run),
    .step_i      (step),
    .addra_o     (addra),
    .addrb_o     (addrb),
    .operacion_o (operacion),
    .invert_o    (invert),
    .c_o         (c),
    .index_o     (index),
    .adv_o       (adv),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_adv(input int limit, output int n);
    n = 0;
    forever begin
      tick(1);
      n++;
      if (adv === 1'b1 || n >= limit) break;
    end
    if (adv !== 1'b1) check("adv_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_state(input logic [1:0] st, input int limit);
    int n;
    n = 0;
    while (dut.state !== st && n < limit) begin
      tick(1);
      n++;
    end
    check("state_wait", {30'd0, dut.state}, {30'd0, st});
  endtask

  task automatic press();
    step = 1'b1;
    tick(3);
    step = 1'b0;
    tick(4);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_index"}, index, 0);
    check({tag, "_addra"}, addra, 0);
    check({tag, "_addrb"}, addrb, 0);
    check({tag, "_op"}, operacion, 4'b0000);
    check({tag, "_inv_c"}, {invert, c}, 2'b00);
    check({tag, "_adv_done"}, {adv, done}, 2'b00);
    check({tag, "_state"}, {30'd0, dut.state}, 2'd0);
  endtask

  initial begin
    rst  = 1'b1;
    run  = 1'b0;
    step = 1'b0;
    tick(3);
    check_reset_vals("reset");

    // Auto-run: advance every DWELL cycles, addrb wraps into addra at index 8
    rst = 1'b0;
    tick(1);
    run = 1'b1;
    wait_adv(20, cyc);
    check("first_adv_index", index, 1);
    for (int k = 2; k <= 37; k++) begin
      wait_adv(10, cyc);
      check("auto_interval", cyc, DWELL);
      check("auto_index", index, k);
      if (k == 8) begin
        check("wrap_addrb", addrb, 0);
        check("wrap_addra", addra, 1);
      end
    end

    // Asynchronous reset mid-AUTO at index 37
    #2;
    rst = 1'b1;
    run = 1'b0;
    #1;
    check_reset_vals("async_rst");
    tick(2);
    rst = 1'b0;
    tick(1);

    // Full sweep to the last combination, then DONE
    run = 1'b1;
    exp_idx = 0;
    while (exp_idx < 511) begin
      wait_adv(20, cyc);
      exp_idx++;
      check("sweep_index", index, exp_idx);
      if (index !== IW'(exp_idx)) break;
    end
    check("last_op", operacion, 4'b1001);
    check("last_addr", {addra, addrb}, 6'b111_111);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick(1);
      cyc++;
    end
    check("done_delay", cyc, DWELL);
    adv_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (adv === 1'b1) adv_seen++;
    end
    check("done_no_adv", adv_seen, 0);
    check("done_hold_index", index, 511);
    check("done_level", done, 1);
    run = 1'b0;
    tick(4);
    check_reset_vals("done_to_idle");

    // Step mode: first step leaves IDLE without advancing
    press();
    check("idle_step_state", {30'd0, dut.state}, 2'd2);
    check("idle_step_index", index, 0);
    for (int k = 0; k < 24; k++) press();
    check("step24_index", index, 24);
    check("step24_addra", addra, 3);
    check("step24_addrb", addrb, 0);
    check("step24_op", operacion, 4'b0000);
    for (int k = 0; k < 167; k++) press();
    check("step191_op", operacion, 4'b0010);
    check("step191_inv_c", {invert, c}, 2'b00);
    press();
    check("sub_index", index, 192);
    check("sub_op", operacion, 4'b0110);
    check("sub_inv_c", {invert, c}, 2'b11);
    for (int k = 0; k < 64; k++) press();
    check("sltu_index", index, 256);
    check("sltu_op", operacion, 4'b0101);
    check("sltu_inv_c", {invert, c}, 2'b00);

    // Freeze the dwell count at 2 by leaving AUTO briefly
    run = 1'b1;
    wait_state(2'd1, 10);
    run = 1'b0;
    tick(3);
    check("freeze_state", {30'd0, dut.state}, 2'd2);
    check("freeze_index", index, 256);

    // Step and run arrive at the FSM together: AUTO wins, step ignored
    step = 1'b1;
    tick(1);
    run = 1'b1;
    wait_state(2'd1, 10);
    check("coincide_index", index, 256);
    wait_adv(10, cyc);
    check("resume_delay", cyc, DWELL - 2);
    check("resume_index", index, 257);
    step = 1'b0;
    run  = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
